lcd_cmd_seq: RTL and testbench
==============================

LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 Parameter DEPTH, default 8, command-queue depth in entries; power of two, 2..16.
REQ-002 Parameter CMD_W, default 4, command code width.
REQ-003 Parameter ACK_TMO, default 4, cycles allowed for busy to rise after an issue.
REQ-004 clk  input  1  sole clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-006 host_cmd  input  CMD_W  command code offered by host.
REQ-007 host_push  input  1  one-cycle enqueue strobe for host_cmd.
REQ-008 host_full  output  1  queue holds DEPTH entries.
REQ-009 host_count  output  5  current queue occupancy, 0..DEPTH.
REQ-010 cmd  output  CMD_W  command to the LCD controller.
REQ-011 cmd_valid  output  1  cmd is valid this cycle.
REQ-012 busy  input  1  LCD controller busy.
REQ-013 done  input  1  LCD controller finished the image write-back.
REQ-014 seq_idle  output  1  FSM in IDLE and queue empty.
REQ-015 issued_cnt  output  8  commands issued since reset, wraps 255->0.
REQ-016 err_flags  output  3  sticky: bit0 invalid code, bit1 overflow, bit2 ack timeout.
REQ-017 done_seen  output  1  sticky: done observed after a write command.

Function
REQ-018 Valid codes SHALL be 0x0..0xB (0 = write); codes 0xC..0xF SHALL be dropped at push and set err_flags[0].
REQ-019 Push when full and no pop in that cycle SHALL drop the entry and set err_flags[1]; push and pop in the same cycle when full SHALL be accepted, count unchanged.
REQ-020 Queue SHALL be FIFO-ordered, with read/write pointers wrapping modulo DEPTH.
REQ-021 FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_FREE, WAIT_DONE.
REQ-022 IDLE: if count>0 and busy==0, register cmd=head, cmd_valid=1, pop, increment issued_cnt, go to ISSUE.
REQ-023 ISSUE: cmd_valid SHALL stay high for exactly one cycle; the next cycle drives cmd_valid=0 and goes to WAIT_ACK.
REQ-024 cmd SHALL hold its last issued value while cmd_valid=0.
REQ-025 WAIT_ACK: busy==1 goes to WAIT_FREE; after ACK_TMO cycles without busy, set err_flags[2] and go to IDLE.
REQ-026 WAIT_FREE: on busy==0, if the last cmd was 0 go to WAIT_DONE, else go to IDLE.
REQ-027 WAIT_DONE: on done==1, set done_seen and go to IDLE; no issue SHALL occur in this state.
REQ-028 Issue-to-next-issue minimum spacing SHALL be 4 cycles (ISSUE, WAIT_ACK, WAIT_FREE, IDLE).
REQ-029 done asserted outside WAIT_DONE SHALL be ignored.
REQ-030 Pushes SHALL be accepted in every FSM state.

Reset
REQ-031 With reset==0 at posedge: queue emptied, FSM=IDLE, cmd=0, cmd_valid=0, host_count=0, host_full=0, issued_cnt=0, err_flags=0, done_seen=0, seq_idle=1.
REQ-032 Reset mid-operation SHALL abort any state within one cycle, with no further cmd_valid pulse.
REQ-033 host_push during reset SHALL be ignored.

Structure
REQ-034 Shared package lcd_pkg SHALL hold the command-code constants (CMD_WRITE=0 .. CMD_MIRROR_Y=0xB), CMD_MAX_VALID, and the FSM state enum.
REQ-035 The queue SHALL be a sub-module cmd_fifo (DEPTH, CMD_W) providing push, pop, full, empty and count.

Verification
REQ-036 Reset, push 3,5,0 with busy pulsed 2 cycles after each issue -> cmd_valid pulses carry 3,5,0 in order; issued_cnt=3; done pulse -> done_seen=1.
REQ-037 Push 0xC, then 0xF -> host_count stays 0, err_flags=3'b001, no cmd_valid.
REQ-038 Hold busy=1, push 9 entries of code 1 -> host_full=1 after 8, err_flags[1]=1, count=8; release busy -> 8 issues observed.
REQ-039 Push 4 and never raise busy -> err_flags[2]=1 exactly ACK_TMO cycles after WAIT_ACK entry, FSM back to IDLE, next entry issued.
REQ-040 Queue full with push and issue-pop in the same cycle -> entry accepted, count stays 8, no overflow flag.
REQ-041 Assert reset during WAIT_FREE with 5 entries queued -> next cycle count=0, cmd_valid=0, seq_idle=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared definitions for the LCD command sequencer.
//   - Command codes understood by the LCD controller (0x0..0xB).
//   - CMD_MAX_VALID: highest code accepted into the queue.
//   - seq_state_t: sequencer FSM states.
package lcd_pkg;

   localparam logic [3:0] CMD_WRITE     = 4'h0;
   localparam logic [3:0] CMD_CLEAR     = 4'h1;
   localparam logic [3:0] CMD_HOME      = 4'h2;
   localparam logic [3:0] CMD_DISP_ON   = 4'h3;
   localparam logic [3:0] CMD_DISP_OFF  = 4'h4;
   localparam logic [3:0] CMD_CONTRAST  = 4'h5;
   localparam logic [3:0] CMD_INVERT    = 4'h6;
   localparam logic [3:0] CMD_NORMAL    = 4'h7;
   localparam logic [3:0] CMD_SCROLL    = 4'h8;
   localparam logic [3:0] CMD_SLEEP     = 4'h9;
   localparam logic [3:0] CMD_MIRROR_X  = 4'hA;
   localparam logic [3:0] CMD_MIRROR_Y  = 4'hB;

   // Kept 32 bits wide so it can be compared against a zero-extended code
   // of any CMD_W.
   localparam logic [31:0] CMD_MAX_VALID = 32'd11;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_ACK  = 3'd2,
      ST_WAIT_FREE = 3'd3,
      ST_WAIT_DONE = 3'd4
   } seq_state_t;

endpackage

// File: rtl/lcd_cmd_seq_fifo.sv
// cmd_fifo
// Command queue for the LCD sequencer. Synchronous FIFO with pointers
// that wrap modulo DEPTH (DEPTH must be a power of two).
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   push, push_data enqueue request and data
//   pop             dequeue request (ignored when empty)
//   head            entry at the read pointer
//   full, empty     occupancy flags
//   count           occupancy 0..DEPTH
module cmd_fifo
   import lcd_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CMD_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [CMD_W-1:0] push_data,
   input  logic             pop,
   output logic [CMD_W-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [4:0]       count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CMD_W-1:0] mem_q [DEPTH];
   logic [CMD_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [4:0]       count_q, count_d;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count_q == 5'(DEPTH));
   assign empty = (count_q == 5'd0);
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   // A write into a full queue is still legal when a pop frees a slot
   // on the same edge; the occupancy then stays unchanged.
   always_comb begin
      rd_en    = pop && !empty;
      wr_en    = push && (!full || rd_en);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (wr_en && !rd_en) begin
         count_d = count_q + 5'd1;
      end else if (!wr_en && rd_en) begin
         count_d = count_q - 5'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= 5'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq
// Queues host commands and issues them one at a time to an LCD controller
// using a busy handshake, waiting for image write-back after write commands.
// Ports:
//   clk, reset         clock, synchronous active-low reset
//   host_cmd/push      command offered by the host and its enqueue strobe
//   host_full/count    queue full flag and occupancy
//   cmd, cmd_valid     command to the controller, one-cycle valid pulse
//   busy, done         controller busy level and write-back done strobe
//   seq_idle           nothing queued and FSM idle
//   issued_cnt         commands issued since reset (wraps)
//   err_flags          sticky {ack timeout, overflow, invalid code}
//   done_seen          sticky: write-back completion observed
module lcd_cmd_seq
   import lcd_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int CMD_W   = 4,
   parameter int ACK_TMO = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CMD_W-1:0] host_cmd,
   input  logic             host_push,
   output logic             host_full,
   output logic [4:0]       host_count,
   output logic [CMD_W-1:0] cmd,
   output logic             cmd_valid,
   input  logic             busy,
   input  logic             done,
   output logic             seq_idle,
   output logic [7:0]       issued_cnt,
   output logic [2:0]       err_flags,
   output logic             done_seen
);

   localparam int TMO_W = (ACK_TMO > 1) ? $clog2(ACK_TMO + 1) : 1;

   seq_state_t       state_q, state_d;
   logic [CMD_W-1:0] cmd_q, cmd_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic [7:0]       issued_q, issued_d;
   logic [2:0]       err_q, err_d;
   logic             done_seen_q, done_seen_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;

   logic             code_ok;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CMD_W-1:0] fifo_head;

   // Invalid codes never reach the queue.
   assign code_ok   = (32'(host_cmd) <= CMD_MAX_VALID);
   assign fifo_push = host_push && code_ok;

   cmd_fifo #(
      .DEPTH (DEPTH),
      .CMD_W (CMD_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (host_cmd),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (host_count)
   );

   assign host_full  = fifo_full;
   assign cmd        = cmd_q;
   assign cmd_valid  = cmd_valid_q;
   assign issued_cnt = issued_q;
   assign err_flags  = err_q;
   assign done_seen  = done_seen_q;
   assign seq_idle   = (state_q == ST_IDLE) && fifo_empty;

   // cmd_valid is registered and only set on the IDLE->ISSUE transition,
   // so it is high for exactly the one cycle spent in ISSUE.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      cmd_valid_d = 1'b0;
      issued_d    = issued_q;
      tmo_d       = tmo_q;
      done_seen_d = done_seen_q;
      fifo_pop    = 1'b0;
      err_d       = err_q;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && !busy) begin
               cmd_d       = fifo_head;
               cmd_valid_d = 1'b1;
               fifo_pop    = 1'b1;
               issued_d    = issued_q + 8'd1;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            tmo_d   = '0;
            state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (busy) begin
               state_d = ST_WAIT_FREE;
            end else if (tmo_q == TMO_W'(ACK_TMO - 1)) begin
               err_d[2] = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_WAIT_FREE: begin
            if (!busy) begin
               state_d = (cmd_q == CMD_W'(CMD_WRITE)) ? ST_WAIT_DONE : ST_IDLE;
            end
         end
         ST_WAIT_DONE: begin
            if (done) begin
               done_seen_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Overflow only when the queue is full and no issue frees a slot.
      if (host_push && !code_ok) begin
         err_d[0] = 1'b1;
      end
      if (fifo_push && fifo_full && !fifo_pop) begin
         err_d[1] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         issued_q    <= 8'd0;
         err_q       <= 3'b000;
         done_seen_q <= 1'b0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         issued_q    <= issued_d;
         err_q       <= err_d;
         done_seen_q <= done_seen_d;
         tmo_q       <= tmo_d;
      end
   end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// tb_lcd_cmd_seq
// Self-checking bench for lcd_cmd_seq. Every accepted command is pushed to
// a scoreboard queue when driven; each cmd_valid pulse pops and compares.
module tb_lcd_cmd_seq;

   localparam int DEPTH   = 8;
   localparam int CMD_W   = 4;
   localparam int ACK_TMO = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [CMD_W-1:0] host_cmd;
   logic             host_push;
   logic             host_full;
   logic [4:0]       host_count;
   logic [CMD_W-1:0] cmd;
   logic             cmd_valid;
   logic             busy;
   logic             done;
   logic             seq_idle;
   logic [7:0]       issued_cnt;
   logic [2:0]       err_flags;
   logic             done_seen;

   int               checks     = 0;
   int               fails      = 0;
   int               valid_seen = 0;
   logic [CMD_W-1:0] sb [$];
   bit               busy_auto  = 1'b0;

   lcd_cmd_seq #(
      .DEPTH   (DEPTH),
      .CMD_W   (CMD_W),
      .ACK_TMO (ACK_TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .host_cmd   (host_cmd),
      .host_push  (host_push),
      .host_full  (host_full),
      .host_count (host_count),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .busy       (busy),
      .done       (done),
      .seq_idle   (seq_idle),
      .issued_cnt (issued_cnt),
      .err_flags  (err_flags),
      .done_seen  (done_seen)
   );

   always #5 clk = ~clk;

   // Scoreboard consumer: every issue must match the oldest expected command.
   always @(negedge clk) begin : monitor
      logic [CMD_W-1:0] exp_cmd;
      if (cmd_valid === 1'b1) begin
         valid_seen++;
         checks++;
         if (sb.size() == 0) begin
            fails++;
            $display("[TB] FAIL issue_order: cmd_valid with cmd=%0h, required no issue", cmd);
         end else begin
            exp_cmd = sb.pop_front();
            if (cmd !== exp_cmd) begin
               fails++;
               $display("[TB] FAIL issue_order: cmd=%0h, required %0h", cmd, exp_cmd);
            end
         end
      end
   end

   // Controller model: raises busy two cycles after an issue for two cycles.
   initial begin : responder
      forever begin
         @(negedge clk);
         if (busy_auto && cmd_valid === 1'b1) begin
            @(posedge clk);
            @(posedge clk);
            #1;
            if (busy_auto) busy = 1'b1;
            @(posedge clk);
            @(posedge clk);
            #1;
            if (busy_auto) busy = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic apply_reset();
      busy_auto = 1'b0;
      reset     = 1'b0;
      host_push = 1'b0;
      host_cmd  = '0;
      busy      = 1'b0;
      done      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
   endtask

   // Drives one push for one clock; records it when it should be accepted.
   task automatic push_one(input logic [CMD_W-1:0] c, input bit accept);
      host_cmd  = c;
      host_push = 1'b1;
      if (accept) sb.push_back(c);
      @(posedge clk);
      #1;
      host_push = 1'b0;
   endtask

   task automatic wait_drain(input int max_cycles, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_issue(input int max_cycles, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (cmd_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      host_cmd  = 4'h2;
      host_push = 1'b1;
      busy      = 1'b0;
      done      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({cmd_valid, host_full, done_seen, seq_idle} !== 4'b0001) begin
         fails++;
         $display("[TB] FAIL reset_flags: valid/full/done/idle=%b, required 0001",
                  {cmd_valid, host_full, done_seen, seq_idle});
      end
      checks++;
      if (host_count !== 5'd0 || cmd !== 4'h0) begin
         fails++;
         $display("[TB] FAIL reset_count_cmd: count=%0d cmd=%0h, required 0 0", host_count, cmd);
      end
      checks++;
      if (issued_cnt !== 8'd0 || err_flags !== 3'b000) begin
         fails++;
         $display("[TB] FAIL reset_counters: issued=%0d err=%b, required 0 000", issued_cnt, err_flags);
      end
      host_push = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      checks++;
      if (host_count !== 5'd0) begin
         fails++;
         $display("[TB] FAIL reset_push_ignored: count=%0d, required 0", host_count);
      end
   endtask

   task automatic test_basic();
      bit ok;
      @(posedge clk);
      #1;
      done = 1'b1;
      @(posedge clk);
      #1;
      done = 1'b0;
      @(negedge clk);
      checks++;
      if (done_seen !== 1'b0) begin
         fails++;
         $display("[TB] FAIL done_ignored_idle: done_seen=%b, required 0", done_seen);
      end
      busy_auto = 1'b1;
      @(posedge clk);
      #1;
      push_one(4'h3, 1'b1);
      push_one(4'h5, 1'b1);
      push_one(4'h0, 1'b1);
      wait_drain(200, ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("[TB] FAIL drain_basic: %0d outstanding, required 0", sb.size());
      end
      repeat (10) @(negedge clk);
      checks++;
      if (issued_cnt !== 8'd3) begin
         fails++;
         $display("[TB] FAIL issued_basic: issued=%0d, required 3", issued_cnt);
      end
      checks++;
      if (seq_idle !== 1'b0 || done_seen !== 1'b0) begin
         fails++;
         $display("[TB] FAIL wait_done_hold: idle=%b done_seen=%b, required 0 0", seq_idle, done_seen);
      end
      @(posedge clk);
      #1;
      done = 1'b1;
      @(posedge clk);
      #1;
      done = 1'b0;
      @(negedge clk);
      checks++;
      if (done_seen !== 1'b1 || seq_idle !== 1'b1) begin
         fails++;
         $display("[TB] FAIL done_basic: done_seen=%b idle=%b, required 1 1", done_seen, seq_idle);
      end
   endtask

   task automatic test_invalid();
      bit ok;
      int seen;
      apply_reset();
      seen = valid_seen;
      push_one(4'hC, 1'b0);
      push_one(4'hF, 1'b0);
      repeat (5) @(negedge clk);
      checks++;
      if (host_count !== 5'd0 || err_flags !== 3'b001) begin
         fails++;
         $display("[TB] FAIL invalid_drop: count=%0d err=%b, required 0 001", host_count, err_flags);
      end
      checks++;
      if (valid_seen !== seen) begin
         fails++;
         $display("[TB] FAIL invalid_no_issue: issues=%0d, required %0d", valid_seen, seen);
      end
      busy_auto = 1'b1;
      push_one(4'hB, 1'b1);
      @(negedge clk);
      checks++;
      if (host_count !== 5'd1) begin
         fails++;
         $display("[TB] FAIL max_code_accept: count=%0d, required 1", host_count);
      end
      wait_drain(100, ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("[TB] FAIL drain_invalid: %0d outstanding, required 0", sb.size());
      end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_overflow();
      bit ok;
      apply_reset();
      busy = 1'b1;
      for (int i = 0; i < DEPTH; i++) push_one(4'h1, 1'b1);
      @(negedge clk);
      checks++;
      if (host_full !== 1'b1 || host_count !== 5'd8 || err_flags[1] !== 1'b0) begin
         fails++;
         $display("[TB] FAIL fill: full=%b count=%0d ovf=%b, required 1 8 0",
                  host_full, host_count, err_flags[1]);
      end
      push_one(4'h1, 1'b0);
      @(negedge clk);
      checks++;
      if (err_flags !== 3'b010 || host_count !== 5'd8) begin
         fails++;
         $display("[TB] FAIL overflow: err=%b count=%0d, required 010 8", err_flags, host_count);
      end
      busy      = 1'b0;
      busy_auto = 1'b1;
      wait_drain(300, ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("[TB] FAIL drain_overflow: %0d outstanding, required 0", sb.size());
      end
      repeat (10) @(negedge clk);
      checks++;
      if (issued_cnt !== 8'd8 || seq_idle !== 1'b1) begin
         fails++;
         $display("[TB] FAIL issued_overflow: issued=%0d idle=%b, required 8 1", issued_cnt, seq_idle);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      apply_reset();
      push_one(4'h4, 1'b1);
      push_one(4'h6, 1'b1);
      wait_issue(20, ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("[TB] FAIL timeout_first_issue: no cmd_valid, required issue of 4");
      end
      repeat (ACK_TMO) @(negedge clk);
      checks++;
      if (err_flags[2] !== 1'b0 || cmd !== 4'h4 || cmd_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL timeout_early: tmo=%b cmd=%0h valid=%b, required 0 4 0",
                  err_flags[2], cmd, cmd_valid);
      end
      @(negedge clk);
      checks++;
      if (err_flags !== 3'b100 || seq_idle !== 1'b0) begin
         fails++;
         $display("[TB] FAIL timeout_flag: err=%b idle=%b, required 100 0", err_flags, seq_idle);
      end
      @(negedge clk);
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 4'h6) begin
         fails++;
         $display("[TB] FAIL timeout_next_issue: valid=%b cmd=%0h, required 1 6", cmd_valid, cmd);
      end
      repeat (12) @(negedge clk);
   endtask

   task automatic test_full_push_pop();
      bit ok;
      apply_reset();
      busy = 1'b1;
      for (int i = 0; i < DEPTH; i++) push_one(4'h2, 1'b1);
      @(negedge clk);
      busy      = 1'b0;
      busy_auto = 1'b1;
      push_one(4'h7, 1'b1);
      @(negedge clk);
      checks++;
      if (host_count !== 5'd8 || host_full !== 1'b1 || err_flags[1] !== 1'b0) begin
         fails++;
         $display("[TB] FAIL full_push_pop: count=%0d full=%b ovf=%b, required 8 1 0",
                  host_count, host_full, err_flags[1]);
      end
      wait_drain(300, ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("[TB] FAIL drain_push_pop: %0d outstanding, required 0", sb.size());
      end
      repeat (10) @(negedge clk);
      checks++;
      if (issued_cnt !== 8'd9) begin
         fails++;
         $display("[TB] FAIL issued_push_pop: issued=%0d, required 9", issued_cnt);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int seen;
      apply_reset();
      push_one(4'h1, 1'b1);
      wait_issue(20, ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("[TB] FAIL mid_first_issue: no cmd_valid, required issue of 1");
      end
      busy = 1'b1;
      for (int i = 0; i < 5; i++) push_one(4'h3, 1'b0);
      @(negedge clk);
      checks++;
      if (host_count !== 5'd5) begin
         fails++;
         $display("[TB] FAIL mid_queued: count=%0d, required 5", host_count);
      end
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (host_count !== 5'd0 || cmd_valid !== 1'b0 || seq_idle !== 1'b1 || cmd !== 4'h0) begin
         fails++;
         $display("[TB] FAIL mid_reset: count=%0d valid=%b idle=%b cmd=%0h, required 0 0 1 0",
                  host_count, cmd_valid, seq_idle, cmd);
      end
      seen  = valid_seen;
      reset = 1'b1;
      busy  = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (valid_seen !== seen) begin
         fails++;
         $display("[TB] FAIL mid_no_issue: issues=%0d, required %0d", valid_seen, seen);
      end
   endtask

   initial begin : main
      $display("[TB] lcd_cmd_seq bench start");
      test_reset();
      test_basic();
      test_invalid();
      test_overflow();
      test_timeout();
      test_full_push_pop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
